// File: rtl/multi_digit_display_controller_if.sv
// Display controller bus: value/control inputs from the status registers
// and the registered segment/anode outputs toward the board pins.
interface multi_digit_display_controller_if #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned PWM_BITS   = 4
);
  logic [4*NUM_DIGITS-1:0] val_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    update_in;
  logic [PWM_BITS-1:0]     brightness_in;
  logic [6:0]              cat_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_out;

  modport master (
    output val_in, dp_in, blank_in, update_in, brightness_in,
    input  cat_out, dp_out, an_out, frame_out
  );

  modport slave (
    input  val_in, dp_in, blank_in, update_in, brightness_in,
    output cat_out, dp_out, an_out, frame_out
  );
endinterface

// File: rtl/multi_digit_display_controller.sv
// Time-multiplexed common-anode seven-segment controller with PWM brightness
// and frame-synchronised double-buffered updates.
// Optional macro LEADING_ZERO_BLANK_EN: auto-blank leading zero digits.
module multi_digit_display_controller #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned COUNT_TO   = 100_000,
  parameter int unsigned PWM_BITS   = 4
) (
  input logic clk_in,
  input logic rst_n_in,
  multi_digit_display_controller_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned DW_W  = $clog2(COUNT_TO);

  logic [DW_W-1:0]         r_dwell;
  logic [IDX_W-1:0]        r_idx;
  logic [PWM_BITS-1:0]     r_pwm;

  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic [4*NUM_DIGITS-1:0] r_disp_val;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [NUM_DIGITS-1:0]   r_disp_blank;

  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_cat;
  logic                    r_dp;
  logic                    r_frame;

  logic                    w_dwell_last;
  logic                    w_frame;
  logic [NUM_DIGITS-1:0]   w_lz_blank;
  logic [3:0]              w_nib;
  logic                    w_on;
  logic                    w_dark;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic [6:0]              w_cat_nxt;
  logic                    w_dp_nxt;

  function automatic logic [6:0] f_font(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  assign w_dwell_last = (r_dwell == DW_W'(COUNT_TO - 1));
  assign w_frame      = w_dwell_last && (r_idx == IDX_W'(NUM_DIGITS - 1));

  // Scan timing: dwell counter, digit index and per-digit PWM phase
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_dwell <= '0;
      r_idx   <= '0;
      r_pwm   <= '0;
    end else if (w_dwell_last) begin
      r_dwell <= '0;
      r_pwm   <= '0;
      r_idx   <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_dwell <= r_dwell + DW_W'(1);
      r_pwm   <= r_pwm + PWM_BITS'(1);
    end
  end

  // Double buffer: pending captures on strobe, display swaps only at frame start;
  // a strobe landing on the boundary bypasses pending so it shows this frame
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_disp_blank <= '0;
    end else begin
      if (bus.update_in) begin
        r_pend_val   <= bus.val_in;
        r_pend_dp    <= bus.dp_in;
        r_pend_blank <= bus.blank_in;
      end
      if (w_frame) begin
        r_disp_val   <= bus.update_in ? bus.val_in   : r_pend_val;
        r_disp_dp    <= bus.update_in ? bus.dp_in    : r_pend_dp;
        r_disp_blank <= bus.update_in ? bus.blank_in : r_pend_blank;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and everything above it is zero; digit 0 and dp digits stay lit
  always_comb begin
    w_lz_blank = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      w_lz_blank[i] = ~r_disp_dp[i] & ~|(r_disp_val >> (4 * i));
    end
  end
`else
  // Leading zeros render normally
  always_comb begin
    w_lz_blank = '0;
  end
`endif

  // Next output pattern from current index, PWM phase and display buffer
  always_comb begin
    w_nib     = r_disp_val[{r_idx, 2'b00} +: 4];
    w_on      = (&bus.brightness_in) || (r_pwm < bus.brightness_in);
    w_dark    = r_disp_blank[r_idx] | w_lz_blank[r_idx];
    w_an_nxt  = '1;
    w_cat_nxt = '1;
    w_dp_nxt  = 1'b1;
    if (w_on && !w_dark) begin
      w_an_nxt  = ~(NUM_DIGITS'(1) << r_idx);
      w_cat_nxt = ~f_font(w_nib);
      w_dp_nxt  = ~r_disp_dp[r_idx];
    end
  end

  // Registered pin drivers and frame-start pulse
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_an    <= '1;
      r_cat   <= '1;
      r_dp    <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      r_an    <= w_an_nxt;
      r_cat   <= w_cat_nxt;
      r_dp    <= w_dp_nxt;
      r_frame <= w_frame;
    end
  end

  assign bus.an_out    = r_an;
  assign bus.cat_out   = r_cat;
  assign bus.dp_out    = r_dp;
  assign bus.frame_out = r_frame;

endmodule

// File: tb/tb_multi_digit_display_controller.sv
// Self-checking bench: randomized and directed stimulus against a
// time-based reference model (digit/PWM phase derived from cycle count).
module tb_multi_digit_display_controller;
  localparam int unsigned ND    = 4;
  localparam int unsigned CT    = 16;
  localparam int unsigned PB    = 4;
  localparam int unsigned FRAME = ND * CT;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b1;
  always #5 clk_in = ~clk_in;

  multi_digit_display_controller_if #(.NUM_DIGITS(ND), .PWM_BITS(PB)) bus ();

  multi_digit_display_controller #(
    .NUM_DIGITS(ND),
    .COUNT_TO  (CT),
    .PWM_BITS  (PB)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned cyc     = 0;

  logic [15:0] m_pend_val, m_disp_val;
  logic [3:0]  m_pend_dp, m_disp_dp, m_pend_blank, m_disp_blank;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] tab [16];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tab[n];
  endfunction

  function automatic logic digit_dark(input int unsigned d);
`ifdef LEADING_ZERO_BLANK_EN
    int unsigned hi;
    logic [3:0] nib;
`endif
    if (m_disp_blank[d]) return 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    hi = 0;
    for (int unsigned j = 0; j < ND; j++) begin
      nib = m_disp_val[4*j +: 4];
      if (nib != 4'h0) hi = j;
    end
    if (d > hi && d != 0 && !m_disp_dp[d]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_reset();
    cyc          = 0;
    m_pend_val   = '0;
    m_pend_dp    = '0;
    m_pend_blank = '0;
    m_disp_val   = '0;
    m_disp_dp    = '0;
    m_disp_blank = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an"},    bus.an_out,    32'hF);
    check({tag, "_cat"},   bus.cat_out,   32'h7F);
    check({tag, "_dp"},    bus.dp_out,    32'h1);
    check({tag, "_frame"}, bus.frame_out, 32'h0);
  endtask

  // One clock: predict from the pre-edge state, advance model, compare after edge
  task automatic step();
    int unsigned d;
    int unsigned pwm;
    logic        on;
    logic [3:0]  e_an;
    logic [6:0]  e_cat;
    logic        e_dp, e_frame;
    d   = (cyc / CT) % ND;
    pwm = (cyc % CT) % (1 << PB);
    on  = (bus.brightness_in == 4'hF) || (pwm < bus.brightness_in);
    if (on && !digit_dark(d)) begin
      e_an  = ~(4'b0001 << d);
      e_cat = ~font(m_disp_val[4*d +: 4]);
      e_dp  = ~m_disp_dp[d];
    end else begin
      e_an  = 4'hF;
      e_cat = 7'h7F;
      e_dp  = 1'b1;
    end
    e_frame = ((cyc % FRAME) == FRAME - 1);
    @(posedge clk_in);
    if ((cyc % FRAME) == FRAME - 1) begin
      if (bus.update_in) begin
        m_disp_val = bus.val_in; m_disp_dp = bus.dp_in; m_disp_blank = bus.blank_in;
      end else begin
        m_disp_val = m_pend_val; m_disp_dp = m_pend_dp; m_disp_blank = m_pend_blank;
      end
    end
    if (bus.update_in) begin
      m_pend_val = bus.val_in; m_pend_dp = bus.dp_in; m_pend_blank = bus.blank_in;
    end
    cyc++;
    #1;
    check("an",    bus.an_out,    e_an);
    check("cat",   bus.cat_out,   e_cat);
    check("dp",    bus.dp_out,    e_dp);
    check("frame", bus.frame_out, e_frame);
  endtask

  task automatic run(input int unsigned n);
    repeat (n) step();
  endtask

  task automatic upd(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    bus.val_in    = v;
    bus.dp_in     = dp;
    bus.blank_in  = bl;
    bus.update_in = 1'b1;
    step();
    bus.update_in = 1'b0;
  endtask

  task automatic run_to_boundary();
    while ((cyc % FRAME) != FRAME - 1) step();
  endtask

  // Reset asserted between edges must take effect without a clock
  task automatic mid_reset();
    #3;
    rst_n_in = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (2) begin
      @(posedge clk_in);
      #1;
      check_reset_vals("hold_rst");
    end
    rst_n_in = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.val_in        = 16'h1234;
    bus.dp_in         = '0;
    bus.blank_in      = '0;
    bus.update_in     = 1'b1;
    bus.brightness_in = 4'hF;
    #1 rst_n_in = 1'b0;
    #1 check_reset_vals("por");
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    check_reset_vals("por_hold");
    rst_n_in = 1'b1;
    model_reset();
    step();
    bus.update_in = 1'b0;
    run(3 * FRAME);

    run(20);
    upd(16'hABCD, 4'b0000, 4'b0000);
    run(2 * FRAME);

    run_to_boundary();
    upd(16'h5E7F, 4'b1010, 4'b0000);
    run(FRAME);

    bus.brightness_in = 4'd4;  run(FRAME);
    bus.brightness_in = 4'd0;  run(FRAME);
    bus.brightness_in = 4'd15; run(FRAME);
    bus.brightness_in = 4'd9;  run(FRAME);
    bus.brightness_in = 4'd15;

    upd(16'h1234, 4'b0001, 4'b0100);
    run(2 * FRAME);

    upd(16'h0050, 4'b0000, 4'b0000);
    run(2 * FRAME);
    upd(16'h0000, 4'b0000, 4'b0000);
    run(2 * FRAME);
    upd(16'h0300, 4'b1000, 4'b0000);
    run(2 * FRAME);

    run(37);
    mid_reset();
    run(2 * FRAME);

    for (int unsigned k = 0; k < 800; k++) begin
      if ($urandom_range(0, 15) == 0) bus.brightness_in = 4'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        bus.val_in   = 16'($urandom);
        if ($urandom_range(0, 1) == 0) bus.val_in = bus.val_in & 16'h00FF;
        bus.dp_in    = 4'($urandom);
        bus.blank_in = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
        bus.update_in = 1'b1;
      end else begin
        bus.update_in = 1'b0;
      end
      step();
    end
    bus.update_in = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
